// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// Module: instr_fetch_unit
//
// Purpose
//   Fetches instruction bytes from a synchronous program memory and presents
//   complete instructions (opcode byte plus an optional immediate byte) to the
//   control unit. The first-level length decode is done here: an opcode with
//   bit 7 set (LOAD/MOVI/JMP, STORE) carries one immediate byte, all other
//   opcodes are a single byte. One assembled instruction is buffered and held
//   under valid/ready backpressure. PC redirects (taken JMP) from execute
//   abandon any fetch in progress and restart fetching at the new target.
//
// Parameters
//   ADDR_W    program-memory address / PC width; PC wraps modulo 2**ADDR_W
//   RESET_PC  PC value loaded on reset
//
// Ports
//   clk              in   1       system clock, rising edge
//   rst_n            in   1       asynchronous active-low reset
//   imem_addr        out  ADDR_W  program-memory byte address
//   imem_rd_en       out  1       read strobe; data arrives on imem_rdata next cycle
//   imem_rdata       in   8       read data, valid one cycle after imem_rd_en
//   instr_valid      out  1       instr/imm/instr_pc hold a complete instruction
//   instr_ready      in   1       decoder accepts the instruction this cycle
//   instr            out  8       opcode byte
//   imm              out  8       immediate byte; 8'h00 for one-byte instructions
//   instr_pc         out  ADDR_W  address of the opcode byte
//   redirect_valid   in   1       load PC from redirect_target
//   redirect_target  in   ADDR_W  new PC
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd_en,
    input  logic [7:0]        imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr,
    output logic [7:0]        imm,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target
);

    typedef enum logic [2:0] {
        S_RST,
        S_F_OP,
        S_W_OP,
        S_W_IMM,
        S_HOLD
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PC_STEP_TWO = ADDR_W'(2);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic              opcode_two_byte;
    logic              held_two_byte;

    // Length decode: the top opcode bit alone selects the two-byte classes.
    assign opcode_two_byte = imem_rdata[7];
    assign held_two_byte   = instr[7];

    // State and PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RST;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Next-state, next-PC and memory interface decode. The memory address
    // follows pc except while requesting the immediate byte, where the
    // natural ADDR_W-bit overflow provides the wrap to address 0.
    // A redirect overrides everything, including an acceptance in HOLD,
    // so the jump target beats the sequential increment.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        imem_rd_en = 1'b0;
        imem_addr  = pc;

        case (state)
            S_RST: begin
                state_next = S_F_OP;
            end
            S_F_OP: begin
                imem_rd_en = 1'b1;
                state_next = S_W_OP;
            end
            S_W_OP: begin
                if (opcode_two_byte) begin
                    imem_rd_en = 1'b1;
                    imem_addr  = pc + PC_STEP_ONE;
                    state_next = S_W_IMM;
                end else begin
                    state_next = S_HOLD;
                end
            end
            S_W_IMM: begin
                state_next = S_HOLD;
            end
            S_HOLD: begin
                if (instr_ready) begin
                    pc_next    = held_two_byte ? (pc + PC_STEP_TWO) : (pc + PC_STEP_ONE);
                    state_next = S_F_OP;
                end
            end
            default: begin
                state_next = S_RST;
            end
        endcase

        if (redirect_valid) begin
            pc_next    = redirect_target;
            state_next = S_F_OP;
        end
    end

    // Instruction assembly. Read data returning during a redirect belongs to
    // the abandoned stream and is dropped. One-byte instructions clear imm so
    // a stale immediate from an earlier instruction is never presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= 8'h00;
            imm      <= 8'h00;
            instr_pc <= RESET_PC;
        end else if (!redirect_valid) begin
            if (state == S_W_OP) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
                if (!opcode_two_byte) begin
                    imm <= 8'h00;
                end
            end else if (state == S_W_IMM) begin
                imm <= imem_rdata;
            end
        end
    end

    // Valid is registered from the decoded next state so it is glitch-free
    // and high exactly while the FSM sits in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid <= 1'b0;
        end else begin
            instr_valid <= (state_next == S_HOLD);
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// Testbench: tb_instr_fetch_unit
//
// Purpose
//   Directed, cycle-by-cycle exercise of instr_fetch_unit. Two instances share
//   clock and reset: the main one starts at PC 00, the second one starts at
//   PC FF to cover the address wrap of a two-byte instruction. Each instance
//   has its own synchronous program-memory model. Inputs change and outputs
//   are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic       clk;
    logic       rst_n;

    logic [7:0] imem_addr;
    logic       imem_rd_en;
    logic [7:0] imem_rdata;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;
    logic [7:0] imm;
    logic [7:0] instr_pc;
    logic       redirect_valid;
    logic [7:0] redirect_target;

    logic [7:0] w_imem_addr;
    logic       w_imem_rd_en;
    logic [7:0] w_imem_rdata;
    logic       w_instr_valid;
    logic       w_instr_ready;
    logic [7:0] w_instr;
    logic [7:0] w_imm;
    logic [7:0] w_instr_pc;

    logic [7:0] mem   [256];
    logic [7:0] w_mem [256];

    int checks;
    int errors;
    int rd_count;

    instr_fetch_unit #(
        .ADDR_W   (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_rd_en      (imem_rd_en),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .imm             (imm),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
    );

    instr_fetch_unit #(
        .ADDR_W   (8),
        .RESET_PC (8'hFF)
    ) dut_wrap (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (w_imem_addr),
        .imem_rd_en      (w_imem_rd_en),
        .imem_rdata      (w_imem_rdata),
        .instr_valid     (w_instr_valid),
        .instr_ready     (w_instr_ready),
        .instr           (w_instr),
        .imm             (w_imm),
        .instr_pc        (w_instr_pc),
        .redirect_valid  (1'b0),
        .redirect_target (8'h00)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous program memories: data one cycle after the read strobe.
    // The main memory also counts issued reads.
    always @(posedge clk) begin
        if (imem_rd_en) begin
            imem_rdata <= mem[imem_addr];
            rd_count   <= rd_count + 1;
        end
        if (w_imem_rd_en) begin
            w_imem_rdata <= w_mem[w_imem_addr];
        end
    end

    task automatic applyStimulus(input logic ready, input logic redir, input logic [7:0] target);
        instr_ready     = ready;
        redirect_valid  = redir;
        redirect_target = target;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rd_count      = 0;
        imem_rdata    = 8'h00;
        w_imem_rdata  = 8'h00;
        w_instr_ready = 1'b0;
        rst_n         = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 256; i++) begin
            mem[i]   = 8'h00;
            w_mem[i] = 8'h00;
        end
        mem[8'h00]   = 8'h18;
        mem[8'h01]   = 8'h98;
        mem[8'h02]   = 8'h5A;
        mem[8'h03]   = 8'h05;
        mem[8'h04]   = 8'hC1;
        mem[8'h05]   = 8'h77;
        mem[8'h40]   = 8'hA5;
        mem[8'h41]   = 8'h11;
        w_mem[8'hFF] = 8'h84;
        w_mem[8'h00] = 8'h33;

        // t=10: reset state of both instances.
        nextCycle();
        checkOutput("rst_valid", instr_valid, 1'b0);
        checkOutput("rst_rd_en", imem_rd_en, 1'b0);
        checkOutput("rst_addr", imem_addr, 8'h00);
        checkOutput("rst_instr", instr, 8'h00);
        checkOutput("rst_imm", imm, 8'h00);
        checkOutput("rst_instr_pc", instr_pc, 8'h00);
        checkOutput("w_rst_instr_pc", w_instr_pc, 8'hFF);
        checkOutput("w_rst_addr", w_imem_addr, 8'hFF);
        rst_n = 1'b1;

        // t=20: F_OP for both.
        nextCycle();
        checkOutput("fop0_rd_en", imem_rd_en, 1'b1);
        checkOutput("fop0_addr", imem_addr, 8'h00);
        checkOutput("w_fop_addr", w_imem_addr, 8'hFF);
        checkOutput("w_fop_rd_en", w_imem_rd_en, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h00);

        // t=30: W_OP; one-byte opcode issues no further read. Wrap instance
        // asks for its immediate at address 00.
        nextCycle();
        checkOutput("wop0_rd_en", imem_rd_en, 1'b0);
        checkOutput("wop0_valid", instr_valid, 1'b0);
        checkOutput("w_imm_addr", w_imem_addr, 8'h00);
        checkOutput("w_imm_rd_en", w_imem_rd_en, 1'b1);

        // t=40: third cycle after F_OP, one-byte instruction valid.
        nextCycle();
        checkOutput("i0_valid", instr_valid, 1'b1);
        checkOutput("i0_instr", instr, 8'h18);
        checkOutput("i0_imm", imm, 8'h00);
        checkOutput("i0_instr_pc", instr_pc, 8'h00);
        checkOutput("w_wimm_valid", w_instr_valid, 1'b0);

        // t=50: next fetch at 01. Wrap instance valid in its fourth cycle.
        nextCycle();
        checkOutput("fop1_rd_en", imem_rd_en, 1'b1);
        checkOutput("fop1_addr", imem_addr, 8'h01);
        checkOutput("fop1_valid", instr_valid, 1'b0);
        checkOutput("w_valid", w_instr_valid, 1'b1);
        checkOutput("w_instr", w_instr, 8'h84);
        checkOutput("w_imm", w_imm, 8'h33);
        checkOutput("w_instr_pc", w_instr_pc, 8'hFF);
        rd_count      = 0;
        w_instr_ready = 1'b1;

        // t=60: W_OP of two-byte 98, immediate read at 02.
        nextCycle();
        checkOutput("wop1_rd_en", imem_rd_en, 1'b1);
        checkOutput("wop1_addr", imem_addr, 8'h02);
        checkOutput("w_next_addr", w_imem_addr, 8'h01);
        checkOutput("w_next_rd_en", w_imem_rd_en, 1'b1);
        w_instr_ready = 1'b0;

        // t=70: W_IMM, not yet valid, no read.
        nextCycle();
        checkOutput("wimm1_valid", instr_valid, 1'b0);
        checkOutput("wimm1_rd_en", imem_rd_en, 1'b0);

        // t=80: two-byte instruction valid, exactly two reads issued.
        nextCycle();
        checkOutput("i1_valid", instr_valid, 1'b1);
        checkOutput("i1_instr", instr, 8'h98);
        checkOutput("i1_imm", imm, 8'h5A);
        checkOutput("i1_instr_pc", instr_pc, 8'h01);
        checkOutput("i1_reads", rd_count, 2);

        // t=90: next fetch at 03; then hold the next instruction off.
        nextCycle();
        checkOutput("fop3_addr", imem_addr, 8'h03);
        checkOutput("fop3_rd_en", imem_rd_en, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        nextCycle();

        // t=110..150: five cycles of backpressure in HOLD.
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            checkOutput("bp_valid", instr_valid, 1'b1);
            checkOutput("bp_instr", instr, 8'h05);
            checkOutput("bp_imm", imm, 8'h00);
            checkOutput("bp_instr_pc", instr_pc, 8'h03);
            checkOutput("bp_rd_en", imem_rd_en, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 8'h00);

        // t=160: one cycle of ready advanced the PC by one.
        nextCycle();
        checkOutput("bp_next_addr", imem_addr, 8'h04);
        checkOutput("bp_next_rd_en", imem_rd_en, 1'b1);
        checkOutput("bp_next_valid", instr_valid, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00);

        // t=170: W_OP of C1, t=180: W_IMM -> redirect to 40.
        nextCycle();
        checkOutput("wop4_addr", imem_addr, 8'h05);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 8'h40);

        // t=190: old instruction dropped, fetch restarts at 40.
        nextCycle();
        checkOutput("redir_valid", instr_valid, 1'b0);
        checkOutput("redir_addr", imem_addr, 8'h40);
        checkOutput("redir_rd_en", imem_rd_en, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00);

        // t=200, 210: still assembling A5 11.
        nextCycle();
        checkOutput("redir_wop_valid", instr_valid, 1'b0);
        nextCycle();
        checkOutput("redir_wimm_valid", instr_valid, 1'b0);

        // t=220: A5 11 valid; accept it together with a redirect to 40.
        nextCycle();
        checkOutput("i40_valid", instr_valid, 1'b1);
        checkOutput("i40_instr", instr, 8'hA5);
        checkOutput("i40_imm", imm, 8'h11);
        checkOutput("i40_instr_pc", instr_pc, 8'h40);
        applyStimulus(1'b1, 1'b1, 8'h40);

        // t=230: redirect beat the +2 increment.
        nextCycle();
        checkOutput("redir_hold_addr", imem_addr, 8'h40);
        checkOutput("redir_hold_rd_en", imem_rd_en, 1'b1);
        checkOutput("redir_hold_valid", instr_valid, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00);

        // t=240: W_OP (immediate read at 41), then reset mid-fetch.
        nextCycle();
        checkOutput("pre_rst_addr", imem_addr, 8'h41);
        checkOutput("pre_rst_instr", instr, 8'hA5);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_rd_en", imem_rd_en, 1'b0);
        checkOutput("arst_addr", imem_addr, 8'h00);
        checkOutput("arst_instr", instr, 8'h00);
        checkOutput("arst_imm", imm, 8'h00);
        checkOutput("arst_instr_pc", instr_pc, 8'h00);
        checkOutput("arst_valid", instr_valid, 1'b0);

        // t=250: release; first cycle is RST with no read.
        nextCycle();
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_rd_en", imem_rd_en, 1'b0);

        // t=260: F_OP at RESET_PC.
        nextCycle();
        checkOutput("post_rst_fop_rd_en", imem_rd_en, 1'b1);
        checkOutput("post_rst_fop_addr", imem_addr, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
